// File: rtl/exp_average_mc.sv
// Multi-channel exponential moving average: one accumulator per channel, one shared multiplier.
// Sample at edge t is folded into its accumulator at t+1 and presented on the outputs at t+2.
module exp_average_mc #(
  parameter int WIDTH       = 16,
  parameter int ALPHA_WIDTH = 32,
  parameter int FRAC_BITS   = 16,
  parameter int N_CH        = 4,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter bit SEED_EN     = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [CH_W-1:0]        chan_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic [ALPHA_WIDTH-1:0] alpha_i,
  input  logic                   clear_i,
  output logic                   valid_o,
  output logic [CH_W-1:0]        chan_o,
  output logic [WIDTH-1:0]       data_o
);

  localparam int ACC_W  = WIDTH + FRAC_BITS;
  localparam int PROD_W = (ACC_W + 1) + (ALPHA_WIDTH + 1);

  logic                          s1_vld_q;
  logic [CH_W-1:0]               s1_ch_q;
  logic [WIDTH-1:0]              s1_dat_q;
  logic [ALPHA_WIDTH-1:0]        s1_alpha_q;

  logic                          s2_vld_q;
  logic [CH_W-1:0]               s2_ch_q;
  logic [WIDTH-1:0]              s2_y_q;

  logic                          valid_q;
  logic [CH_W-1:0]               chan_q;
  logic [WIDTH-1:0]              data_q;

  logic signed [ACC_W-1:0]       acc_q [N_CH];
  logic [N_CH-1:0]               seeded_q;

  logic                          in_ok;
  logic signed [ACC_W-1:0]       acc_cur;
  logic signed [ACC_W:0]         x_sh;
  logic signed [ACC_W:0]         diff;
  logic signed [ALPHA_WIDTH:0]   alpha_s;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_d;

  assign in_ok   = valid_i && ({1'b0, chan_i} < (CH_W + 1)'(N_CH));
  assign alpha_s = {1'b0, s1_alpha_q};

  // The accumulator is read in the cycle after capture and written at the end of it, so a
  // same-channel sample one cycle behind always reads the freshly written value.
  always_comb begin
    acc_cur = acc_q[s1_ch_q];
    x_sh    = {s1_dat_q[WIDTH-1], s1_dat_q, {FRAC_BITS{1'b0}}};
    diff    = x_sh - {acc_cur[ACC_W-1], acc_cur};
    prod    = PROD_W'(diff) * PROD_W'(alpha_s);
    acc_d   = acc_cur + prod[ALPHA_WIDTH +: ACC_W];
    if (SEED_EN && !seeded_q[s1_ch_q]) begin
      acc_d = x_sh[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_dat_q   <= '0;
      s1_alpha_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_ch_q    <= '0;
      s2_y_q     <= '0;
      valid_q    <= 1'b0;
      chan_q     <= '0;
      data_q     <= '0;
      seeded_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      s1_vld_q <= in_ok;
      if (in_ok) begin
        s1_ch_q    <= chan_i;
        s1_dat_q   <= data_i;
        s1_alpha_q <= alpha_i;
      end

      // Clear first; an in-flight write-back on the same edge lands on top of it.
      if (clear_i) begin
        seeded_q <= '0;
        for (int c = 0; c < N_CH; c++) begin
          acc_q[c] <= '0;
        end
      end
      if (s1_vld_q) begin
        acc_q[s1_ch_q]    <= acc_d;
        seeded_q[s1_ch_q] <= 1'b1;
      end

      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_ch_q <= s1_ch_q;
        s2_y_q  <= acc_d[ACC_W-1:FRAC_BITS];
      end

      valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        chan_q <= s2_ch_q;
        data_q <= s2_y_q;
      end
    end
  end

  assign valid_o = valid_q;
  assign chan_o  = chan_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_exp_average_mc.sv
// Bench for exp_average_mc: scoreboard of bit-true expected averages, plus a 3-channel
// instance sharing the stimulus to check that out-of-range channels are ignored.
module tb_exp_average_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i   = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  chan_i  = '0;
  logic [15:0] data_i  = '0;
  logic [31:0] alpha_i = '0;
  logic        clear_i = 1'b0;

  logic        valid_o;
  logic [1:0]  chan_o;
  logic [15:0] data_o;
  logic        v3;
  logic [1:0]  c3;
  logic [15:0] d3;

  exp_average_mc u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .chan_i(chan_i), .data_i(data_i),
    .alpha_i(alpha_i), .clear_i(clear_i), .valid_o(valid_o), .chan_o(chan_o), .data_o(data_o)
  );

  exp_average_mc #(.N_CH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .chan_i(chan_i), .data_i(data_i),
    .alpha_i(alpha_i), .clear_i(clear_i), .valid_o(v3), .chan_o(c3), .data_o(d3)
  );

  typedef struct {
    int                 ch;
    logic signed [15:0] y;
    int                 due;
  } exp_t;

  exp_t   exp_q[$];
  longint m_acc [4];
  bit     m_seed[4];
  int     cyc   = 0;
  int     total = 0;
  int     bad   = 0;

  // Reference in plain 64-bit integers; alpha is split in halves so the product never overflows.
  function automatic logic signed [15:0] mdl(input int c, input logic signed [15:0] x,
                                             input logic [31:0] a);
    longint diff, t, u;
    if (!m_seed[c]) begin
      m_acc[c]  = longint'(x) * 65536;
      m_seed[c] = 1'b1;
    end else begin
      diff     = longint'(x) * 65536 - m_acc[c];
      t        = diff * longint'(a[31:16]);
      u        = diff * longint'(a[15:0]);
      m_acc[c] = m_acc[c] + ((t + (u >>> 16)) >>> 16);
    end
    return 16'(m_acc[c] >>> 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i]  = 0;
      m_seed[i] = 1'b0;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: valid_o=1 chan_o=%0d, required no output", chan_o);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (chan_o !== 2'(e.ch) || data_o !== e.y || cyc != e.due) begin
          bad++;
          $display("FAIL sb_out: chan=%0d data=%0d cyc=%0d, required chan=%0d data=%0d cyc=%0d",
                   chan_o, $signed(data_o), cyc, e.ch, e.y, e.due);
        end
        total++;
        if (v3 !== (e.ch < 3)) begin
          bad++;
          $display("FAIL ch3_valid: v3=%b for chan %0d, required %b", v3, e.ch, (e.ch < 3));
        end else if (v3) begin
          total++;
          if (c3 !== 2'(e.ch) || d3 !== e.y) begin
            bad++;
            $display("FAIL ch3_out: chan=%0d data=%0d, required chan=%0d data=%0d",
                     c3, $signed(d3), e.ch, e.y);
          end
        end
      end
    end else begin
      if (v3 === 1'b1) begin
        total++; bad++;
        $display("FAIL ch3_spurious: v3=1 while main valid_o=%b, required 0", valid_o);
      end
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL sb_missing: valid_o=%b at cyc %0d, required chan=%0d data=%0d",
                 valid_o, cyc, e.ch, e.y);
      end
    end
  endtask

  task automatic drive(input bit v, input int c, input logic signed [15:0] x,
                       input logic [31:0] a, input bit cl);
    exp_t e;
    rst_i   = 1'b0;
    valid_i = v;
    chan_i  = c[1:0];
    data_i  = x;
    alpha_i = a;
    clear_i = cl;
    if (cl) model_reset();
    if (v) begin
      e.ch  = c;
      e.y   = mdl(c, x, a);
      e.due = cyc + 3;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 16'sd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0;
    exp_q.delete();
    model_reset();
    tick(); tick();
    total++;
    if (valid_o !== 1'b0 || chan_o !== 2'd0 || data_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b chan=%0d data=%0d, required 0/0/0",
               valid_o, chan_o, data_o);
    end
    total++;
    if (v3 !== 1'b0 || c3 !== 2'd0 || d3 !== 16'd0) begin
      bad++;
      $display("FAIL reset_state3: valid=%b chan=%0d data=%0d, required 0/0/0", v3, c3, d3);
    end
    rst_i = 1'b0;
    idle(1);
  endtask

  task automatic test_seed();
    drive(1'b1, 0, 16'sd1000, 32'h8000_0000, 1'b0);
    idle(3);
  endtask

  task automatic test_step();
    drive(1'b1, 1, 16'sd0, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1, 16'sd1000, 32'h8000_0000, 1'b0);
    idle(3);
  endtask

  task automatic test_hazard();
    drive(1'b1, 2, 16'sd0, 32'h4000_0000, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2, -16'sd4000, 32'h4000_0000, 1'b0);
    idle(3);
  endtask

  task automatic test_interleave();
    logic signed [15:0] k [4];
    k[0] = 16'sd300; k[1] = -16'sd700; k[2] = 16'sd1234; k[3] = -16'sd20000;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) drive(1'b1, c, k[c], 32'h2000_0000 + 32'(c) * 32'h1000_0000, 1'b0);
    idle(3);
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, -16'sd32768, 32'hFFFF_FFFF, 1'b0);
      drive(1'b1, 3, 16'sd32767, 32'hFFFF_FFFF, 1'b0);
    end
    drive(1'b1, 3, -16'sd32768, 32'd0, 1'b0);
    drive(1'b1, 3, -16'sd32768, 32'd0, 1'b0);
    drive(1'b1, 0, 16'sd32767, 32'd0, 1'b0);
    idle(3);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)), 16'($urandom), a, 1'b0);
    end
    idle(3);
  endtask

  task automatic test_clear();
    drive(1'b1, 0, -16'sd555, 32'h1000_0000, 1'b1);
    drive(1'b1, 1, 16'sd100, 32'h1000_0000, 1'b0);
    drive(1'b1, 0, 16'sd445, 32'h8000_0000, 1'b0);
    drive(1'b1, 3, 16'sd9, 32'h8000_0000, 1'b0);
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 0, 16'sd7000, 32'h4000_0000, 1'b0);
    drive(1'b1, 1, -16'sd3000, 32'h4000_0000, 1'b0);
    exp_q.delete();
    model_reset();
    rst_i = 1'b1; valid_i = 1'b0;
    tick();
    total++;
    if (valid_o !== 1'b0 || chan_o !== 2'd0 || data_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_out: valid=%b chan=%0d data=%0d, required 0/0/0",
               valid_o, chan_o, data_o);
    end
    rst_i = 1'b0;
    tick();
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_flush: valid=%b, required 0", valid_o);
    end
    idle(2);
    drive(1'b1, 1, 16'sd42, 32'h4000_0000, 1'b0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_seed();
    test_step();
    test_hazard();
    test_interleave();
    test_boundary();
    test_clear();
    test_random();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d outputs never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
